// File: rtl/sr_pkg.sv
// Shared types for the sr_latch drive controller.
// State encodings and the counter width helper.
package sr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRV_S = 2'd1,
        ST_DRV_R = 2'd2
    } state_t;

    // Bits needed to count 0..n
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser, debouncer and press detector for one raw push-button.
// rise is a one-cycle pulse registered on the edge stable goes 0->1.
module btn_debounce
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int CW = cnt_w(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CLAST = CW'(DEBOUNCE_CNT - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          hit;

    assign hit = (sync2 != stable) && (cnt == CLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= hit & sync2;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (hit) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Clean, mutually exclusive set/reset pulse driver for an sr_latch.
// Optional SR_SKIP_REDUNDANT_EN drops requests that would not change the latch.
module sr_drive_ctrl
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 4,
    parameter int PULSE_LEN    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int PW = cnt_w(PULSE_LEN);
    localparam logic [PW-1:0] PLAST = PW'(PULSE_LEN - 1);

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] pcnt;
    logic          stb_s;
    logic          stb_r;
    logic          rise_s;
    logic          rise_r;
    logic          req_s;
    logic          req_r;
    logic          acc_s;
    logic          acc_r;
    logic          want_s;
    logic          want_r;
    logic          go_s;
    logic          go_r;
    logic          pend_s;
    logic          pend_r;
    logic          conf_q;

    btn_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_db_s (
        .clk    (clk),
        .rst    (rst),
        .raw    (btn_s),
        .stable (stb_s),
        .rise   (rise_s)
    );

    btn_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_db_r (
        .clk    (clk),
        .rst    (rst),
        .raw    (btn_r),
        .stable (stb_r),
        .rise   (rise_r)
    );

    assign req_s = rise_s & stb_s;
    assign req_r = rise_r & stb_r;

`ifdef SR_SKIP_REDUNDANT_EN
    logic q_model;

    assign acc_r = req_r & q_model;
    assign acc_s = req_s & ~req_r & ~q_model;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_model <= 1'b0;
        end else if (go_s) begin
            q_model <= 1'b1;
        end else if (go_r) begin
            q_model <= 1'b0;
        end
    end
`else
    // Reset wins a same-cycle tie; the set request is discarded
    assign acc_r = req_r;
    assign acc_s = req_s & ~req_r;
`endif

    assign want_s = pend_s | acc_s;
    assign want_r = pend_r | acc_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (want_r) begin
                    state_nx = ST_DRV_R;
                end else if (want_s) begin
                    state_nx = ST_DRV_S;
                end
            end
            ST_DRV_S, ST_DRV_R: begin
                if (pcnt == PLAST) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign go_s = (state == ST_IDLE) && (state_nx == ST_DRV_S);
    assign go_r = (state == ST_IDLE) && (state_nx == ST_DRV_R);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_s <= 1'b0;
            pend_r <= 1'b0;
            pcnt   <= '0;
            conf_q <= 1'b0;
        end else begin
            pend_s <= want_s & ~go_s;
            pend_r <= want_r & ~go_r;
            conf_q <= req_s & req_r;
            if (go_s | go_r) begin
                pcnt <= '0;
            end else if (state != ST_IDLE) begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

    always_comb begin
        s        = 1'b0;
        r        = 1'b0;
        busy     = (state != ST_IDLE) | pend_s | pend_r;
        conflict = conf_q;
        unique case (state)
            ST_DRV_S: s = 1'b1;
            ST_DRV_R: r = 1'b1;
            default:  ;
        endcase
    end

endmodule
